// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch predictor.
//   branch_op_t : branch class of the instruction in Execute
//   CTR_*       : 2-bit direction counter encodings; bit 1 set means predict taken
package bpu_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JUMP = 2'b10
  } branch_op_t;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

endpackage

// File: rtl/bpu_sat_ctr.sv
// 2-bit saturating counter next-state function (purely combinational).
//   ctr_i       : current counter value
//   inc_i       : step toward CTR_ST, holding at CTR_ST
//   dec_i       : step toward CTR_SNT, holding at CTR_SNT
//   force_i     : load force_val_i (takes priority over inc_i/dec_i)
//   force_val_i : value loaded on force_i
//   ctr_o       : next counter value
module bpu_sat_ctr
  import bpu_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       force_i,
  input  logic [1:0] force_val_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (force_i) begin
      ctr_o = force_val_i;
    end else if (inc_i && (ctr_i != CTR_ST)) begin
      ctr_o = ctr_i + 2'd1;
    end else if (dec_i && (ctr_i != CTR_SNT)) begin
      ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor built around a direct-mapped BTB of
// {valid, tag, target, 2-bit counter} entries held in flops.
// Lookup is combinational from pc_f_i; training comes from the Execute stage.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   pc_f_i                : fetch PC to look up
//   pc_e_i, pc_target_e_i : PC and resolved target of the Execute instruction
//   branch_op_e_i         : branch_op_t of the Execute instruction
//   branch_taken_e_i      : resolved direction
//   pc_src_pred_e_i       : prediction that travelled with the instruction
//   target_match_e_i      : predicted target equalled resolved target
//   stall_e_i             : Execute stalled, training blocked
//   pc_src_pred_f_o       : predict taken for pc_f_i
//   pred_pc_target_f_o    : predicted target (0 unless predicted taken)
//   pred_count_o          : [BPU_STATS_EN] branches trained
//   mispred_count_o       : [BPU_STATS_EN] mispredictions seen
module branch_predictor
  import bpu_pkg::*;
#(
  parameter int unsigned ENTRIES = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc_e_i,
  input  logic [31:0] pc_target_e_i,
  input  logic [1:0]  branch_op_e_i,
  input  logic        branch_taken_e_i,
  input  logic        pc_src_pred_e_i,
  input  logic        target_match_e_i,
  input  logic        stall_e_i,
  output logic        pc_src_pred_f_o,
  output logic [31:0] pred_pc_target_f_o
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] pred_count_o,
  output logic [31:0] mispred_count_o
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Fetch lookup
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

  assign idx_f = pc_f_i[IDX_W+1:2];
  assign tag_f = pc_f_i[31:IDX_W+2];
  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

  assign pc_src_pred_f_o    = hit_f && ctr_q[idx_f][1];
  assign pred_pc_target_f_o = pc_src_pred_f_o ? target_q[idx_f] : 32'h0;

  // Execute training
  branch_op_t       op_e;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e, is_cond, is_jump, upd, wr_en;
  logic             ctr_inc, ctr_dec, ctr_force;
  logic [1:0]       ctr_force_val, ctr_d;
  logic [31:0]      target_d;

  assign op_e    = branch_op_t'(branch_op_e_i);
  assign idx_e   = pc_e_i[IDX_W+1:2];
  assign tag_e   = pc_e_i[31:IDX_W+2];
  assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign is_cond = (op_e == BR_COND);
  assign is_jump = (op_e == BR_JUMP);
  assign upd     = (op_e != BR_NONE) && !stall_e_i && !reset_i;

  // A conditional miss that falls through leaves the table alone.
  assign wr_en = upd && (is_jump || (is_cond && (hit_e || branch_taken_e_i)));

  assign ctr_inc       = is_cond && hit_e && branch_taken_e_i;
  assign ctr_dec       = is_cond && hit_e && !branch_taken_e_i;
  assign ctr_force     = is_jump || (is_cond && !hit_e && branch_taken_e_i);
  assign ctr_force_val = is_jump ? CTR_ST : CTR_WT;

  // Not-taken hits keep the old target so a later taken outcome can reuse it.
  assign target_d = (is_jump || branch_taken_e_i) ? pc_target_e_i : target_q[idx_e];

  bpu_sat_ctr u_sat_ctr (
    .ctr_i       (ctr_q[idx_e]),
    .inc_i       (ctr_inc),
    .dec_i       (ctr_dec),
    .force_i     (ctr_force),
    .force_val_i (ctr_force_val),
    .ctr_o       (ctr_d)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[idx_e]  <= 1'b1;
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= target_d;
      ctr_q[idx_e]    <= ctr_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] pred_cnt_q, mispred_cnt_q;
  logic        mispred;

  assign mispred = (pc_src_pred_e_i != branch_taken_e_i) ||
                   (branch_taken_e_i && !target_match_e_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pred_cnt_q    <= 32'h0;
      mispred_cnt_q <= 32'h0;
    end else begin
      if (upd && (is_cond || is_jump)) begin
        pred_cnt_q <= pred_cnt_q + 32'd1;
      end
      if (upd && mispred) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign pred_count_o    = pred_cnt_q;
  assign mispred_count_o = mispred_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{pc_src_pred_e_i, target_match_e_i};
`endif

  // Byte offset within the instruction word plays no part in indexing.
  logic unused_pc;
  assign unused_pc = ^{pc_f_i[1:0], pc_e_i[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: stimulus pushes expected fetch
// predictions into a queue; a monitor pops and compares them mid-cycle.
module tb_branch_predictor;
  import bpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pc_f_i, pc_e_i, pc_target_e_i;
  logic [1:0]  branch_op_e_i;
  logic        branch_taken_e_i, pc_src_pred_e_i, target_match_e_i, stall_e_i;
  logic        pc_src_pred_f_o;
  logic [31:0] pred_pc_target_f_o;
`ifdef BPU_STATS_EN
  logic [31:0] pred_count_o, mispred_count_o;
`endif

  branch_predictor #(.ENTRIES(64)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .pc_f_i             (pc_f_i),
    .pc_e_i             (pc_e_i),
    .pc_target_e_i      (pc_target_e_i),
    .branch_op_e_i      (branch_op_e_i),
    .branch_taken_e_i   (branch_taken_e_i),
    .pc_src_pred_e_i    (pc_src_pred_e_i),
    .target_match_e_i   (target_match_e_i),
    .stall_e_i          (stall_e_i),
    .pc_src_pred_f_o    (pc_src_pred_f_o),
    .pred_pc_target_f_o (pred_pc_target_f_o)
`ifdef BPU_STATS_EN
    ,
    .pred_count_o       (pred_count_o),
    .mispred_count_o    (mispred_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Monitor: fetch outputs are combinational, so sample at the falling edge.
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (pc_src_pred_f_o !== e.taken || pred_pc_target_f_o !== e.target) begin
        n_errors++;
        $display("FAIL %s: got taken=%0b target=%h, want taken=%0b target=%h",
                 e.name, pc_src_pred_f_o, pred_pc_target_f_o, e.taken, e.target);
      end
    end
  end

  // Queue an expectation for the current pc_f_i and advance one cycle.
  task automatic look(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input string name);
    exp_t e;
    pc_f_i   = pc;
    e.taken  = tk;
    e.target = tgt;
    e.name   = name;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_upd(input logic [1:0] op, input logic [31:0] pce, input logic [31:0] tgt,
                         input logic tk, input logic pred, input logic match);
    branch_op_e_i    = op;
    pc_e_i           = pce;
    pc_target_e_i    = tgt;
    branch_taken_e_i = tk;
    pc_src_pred_e_i  = pred;
    target_match_e_i = match;
  endtask

  task automatic clr_upd();
    set_upd(BR_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // One training cycle, then the Execute inputs return to idle.
  task automatic upd(input logic [1:0] op, input logic [31:0] pce, input logic [31:0] tgt,
                     input logic tk);
    set_upd(op, pce, tgt, tk, 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    clr_upd();
  endtask

`ifdef BPU_STATS_EN
  task automatic chk_stats(input logic [31:0] ep, input logic [31:0] em, input string name);
    n_checks++;
    if (pred_count_o !== ep || mispred_count_o !== em) begin
      n_errors++;
      $display("FAIL %s: got pred=%0d mispred=%0d, want pred=%0d mispred=%0d",
               name, pred_count_o, mispred_count_o, ep, em);
    end
  endtask
`endif

  initial begin
    reset_i   = 1'b1;
    stall_e_i = 1'b0;
    pc_f_i    = 32'h0;
    clr_upd();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    look(32'h100, 1'b0, 32'h0, "reset_lookup");

    // Miss+taken allocates at weakly taken.
    upd(BR_COND, 32'h100, 32'h200, 1'b1);
    look(32'h100, 1'b1, 32'h200, "alloc_taken");
    upd(BR_COND, 32'h100, 32'h0, 1'b0);               // 10 -> 01
    look(32'h100, 1'b0, 32'h0, "nt_once");
    upd(BR_COND, 32'h100, 32'h0, 1'b0);               // 01 -> 00
    look(32'h100, 1'b0, 32'h0, "nt_twice");
    upd(BR_COND, 32'h100, 32'h0, 1'b0);               // stays 00
    upd(BR_COND, 32'h100, 32'h200, 1'b1);             // 00 -> 01
    look(32'h100, 1'b0, 32'h0, "sat_low");

    // Saturate upward: 01 -> 10 -> 11 -> 11 -> 11.
    upd(BR_COND, 32'h100, 32'h200, 1'b1);
    look(32'h100, 1'b1, 32'h200, "inc_to_wt");
    repeat (3) upd(BR_COND, 32'h100, 32'h200, 1'b1);
    look(32'h100, 1'b1, 32'h200, "sat_high");
    upd(BR_COND, 32'h100, 32'h0, 1'b0);               // 11 -> 10
    look(32'h102, 1'b1, 32'h200, "sat_then_nt");     // low PC bits ignored

    // Same index, different tag: jump evicts the old entry.
    upd(BR_JUMP, 32'h200, 32'h300, 1'b1);
    look(32'h100, 1'b0, 32'h0, "evicted_tag");
    look(32'h200, 1'b1, 32'h300, "jump_hit");
    look(32'h204, 1'b0, 32'h0, "other_idx_miss");

    // Stalled or BR_NONE activity never trains.
    stall_e_i = 1'b1;
    upd(BR_COND, 32'h200, 32'h400, 1'b1);
    upd(BR_JUMP, 32'h204, 32'h400, 1'b1);
    stall_e_i = 1'b0;
    upd(BR_NONE, 32'h200, 32'h600, 1'b1);
    look(32'h200, 1'b1, 32'h300, "stall_none_hold");
    look(32'h204, 1'b0, 32'h0, "stall_no_alloc");

    // Lookup in the same cycle as an update sees the old contents.
    set_upd(BR_JUMP, 32'h200, 32'h500, 1'b1, 1'b0, 1'b1);
    look(32'h200, 1'b1, 32'h300, "same_cycle_old");
    clr_upd();
    look(32'h200, 1'b1, 32'h500, "next_cycle_new");

    // Conditional miss falling through does not allocate.
    upd(BR_COND, 32'h104, 32'h700, 1'b0);
    upd(BR_COND, 32'h104, 32'h700, 1'b1);             // allocates at 10, not 01->... chain
    look(32'h104, 1'b1, 32'h700, "miss_nt_noalloc");

    // Reset edge with a pending update: update is discarded, table cleared.
    reset_i = 1'b1;
    set_upd(BR_JUMP, 32'h108, 32'h800, 1'b1, 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    clr_upd();
    look(32'h104, 1'b0, 32'h0, "reset_clr_a");
    look(32'h200, 1'b0, 32'h0, "reset_clr_b");
    look(32'h108, 1'b0, 32'h0, "reset_drop_upd");

`ifdef BPU_STATS_EN
    chk_stats(32'd0, 32'd0, "stats_after_reset");
    set_upd(BR_COND, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1);   // correct
    @(posedge clk_i); #1;
    set_upd(BR_COND, 32'h100, 32'h200, 1'b0, 1'b1, 1'b1);   // mispredicted
    @(posedge clk_i); #1;
    set_upd(BR_JUMP, 32'h200, 32'h300, 1'b1, 1'b1, 1'b1);   // correct
    @(posedge clk_i); #1;
    stall_e_i = 1'b1;                                          // stalled: not counted
    set_upd(BR_COND, 32'h100, 32'h200, 1'b0, 1'b1, 1'b1);
    @(posedge clk_i); #1;
    stall_e_i = 1'b0;
    clr_upd();
    chk_stats(32'd3, 32'd1, "stats_counts");
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    chk_stats(32'd0, 32'd0, "stats_reset");
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
